// File: rtl/fp32_pkg.sv
// Shared FP32 definitions used by the operand packer, the MAC and the UART TX path.
package fp32_pkg;

    localparam int FP32_W = 32;
    localparam int BYTE_W = 8;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_t;

endpackage

// File: rtl/fp32_operand_packer_if.sv
// Byte-in / frame-out handshake bundle of the FP32 operand packer.
interface fp32_operand_packer_if #(
    parameter int NUM_WORDS = 3
);
    import fp32_pkg::*;

    logic                          BYTE_VALID_I;
    logic [BYTE_W-1:0]             BYTE_DATA_I;
    logic                          BYTE_READY_O;
    logic                          PACK_VALID_O;
    logic                          PACK_READY_I;
    logic [FP32_W*NUM_WORDS-1:0]   PACK_DATA_O;
    logic                          FRAME_DROP_O;

    modport slave (
        input  BYTE_VALID_I, BYTE_DATA_I, PACK_READY_I,
        output BYTE_READY_O, PACK_VALID_O, PACK_DATA_O, FRAME_DROP_O
    );

    modport master (
        output BYTE_VALID_I, BYTE_DATA_I, PACK_READY_I,
        input  BYTE_READY_O, PACK_VALID_O, PACK_DATA_O, FRAME_DROP_O
    );

endinterface

// File: rtl/fp32_operand_packer.sv
// Packs a little-endian byte stream into NUM_WORDS x 32-bit operand frames for the FP32 MAC.
// Optional partial-frame idle timeout enabled by defining FP32_PACK_TIMEOUT_EN.
module fp32_operand_packer
    import fp32_pkg::*;
#(
    parameter int NUM_WORDS = 3
`ifdef FP32_PACK_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 104160
`endif
) (
    input  logic                 CLK_I,
    input  logic                 RSTL_I,
    fp32_operand_packer_if.slave bus
);

    localparam int NUM_BYTES = (FP32_W / BYTE_W) * NUM_WORDS;
    localparam int FRAME_W   = FP32_W * NUM_WORDS;
    localparam int CNT_W     = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    pack_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [FRAME_W-1:0]   data_q,  data_d;
    logic                 byte_acc;
    logic                 timeout_hit;

    assign byte_acc = bus.BYTE_VALID_I && (state_q == FILL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            FILL: begin
                if (byte_acc) begin
                    data_d[{cnt_q, 3'b000} +: BYTE_W] = bus.BYTE_DATA_I;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else if (timeout_hit) begin
                    cnt_d = '0;
                end
            end
            FULL: begin
                // Frame is held untouched until the MAC takes it.
                if (bus.PACK_READY_I) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign bus.BYTE_READY_O = (state_q == FILL);
    assign bus.PACK_VALID_O = (state_q == FULL);
    assign bus.PACK_DATA_O  = data_q;

`ifdef FP32_PACK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              drop_q;
    logic              idle_run;

    // A byte accepted in the expiry cycle suppresses the drop.
    assign idle_run    = (state_q == FILL) && (cnt_q != '0) && !byte_acc;
    assign timeout_hit = idle_run && (idle_q == IDLE_LAST);

    always_comb begin
        idle_d = '0;
        if (idle_run && !timeout_hit) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            idle_q <= '0;
            drop_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            drop_q <= timeout_hit;
        end
    end

    assign bus.FRAME_DROP_O = drop_q;
`else
    assign timeout_hit      = 1'b0;
    assign bus.FRAME_DROP_O = 1'b0;
`endif

endmodule

// File: tb/tb_fp32_operand_packer.sv
// Directed, table-driven bench for fp32_operand_packer (default build or FP32_PACK_TIMEOUT_EN).
module tb_fp32_operand_packer;

    typedef struct packed {
        logic [95:0] seq;   // bytes in send order, first byte in the MSBs
        logic [95:0] exp;   // hand-packed frame, little-endian
    } vec_t;

    logic clk;
    logic rstl;
    vec_t vt [4];
    logic [95:0] rxq [$];
    int vld_cycles;
    int drop_cycles;
    int total_cnt;
    int pass_cnt;

    fp32_operand_packer_if #(.NUM_WORDS(3)) bus ();

    fp32_operand_packer #(
        .NUM_WORDS(3)
`ifdef FP32_PACK_TIMEOUT_EN
       ,.TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .CLK_I (clk),
        .RSTL_I(rstl),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.PACK_VALID_O && bus.PACK_READY_I) rxq.push_back(bus.PACK_DATA_O);
        if (bus.PACK_VALID_O) vld_cycles <= vld_cycles + 1;
        if (bus.FRAME_DROP_O) drop_cycles <= drop_cycles + 1;
    end

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    endtask

    task automatic chk_frame(input string name, input logic [95:0] exp);
        if (rxq.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: no frame received, expected 0x%h", name, exp);
        end else begin
            chk(name, rxq.pop_front(), exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.BYTE_VALID_I = 1'b1;
        bus.BYTE_DATA_I  = b;
        while (!bus.BYTE_READY_O && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.BYTE_READY_O) begin
            total_cnt++;
            $display("FAIL byte_ready_wait: got ready=0 after %0d cycles, expected ready=1", n);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.BYTE_VALID_I = 1'b0;
    endtask

    task automatic send_seq(input logic [95:0] seq, input int first, input int last, input int maxgap);
        for (int k = first; k <= last; k++) begin
            if (maxgap > 0) wait_cyc(int'($urandom_range(0, maxgap)));
            send_byte(seq[95-8*k -: 8]);
        end
    endtask

    initial begin
        logic [95:0] held;
        int v0;
        logic stable;

        vt[0] = '{seq: 96'h0000803F_00000040_00004040, exp: 96'h40400000_40000000_3F800000};
        vt[1] = '{seq: 96'h01020304_05060708_090A0B0C, exp: 96'h0C0B0A09_08070605_04030201};
        vt[2] = '{seq: 96'hFF00AA55_12345678_DEADBEEF, exp: 96'hEFBEADDE_78563412_55AA00FF};
        vt[3] = '{seq: 96'h0000C07F_000080FF_01000000, exp: 96'h00000001_FF800000_7FC00000};

        total_cnt = 0;
        pass_cnt  = 0;
        vld_cycles  = 0;
        drop_cycles = 0;
        rstl = 1'b0;
        bus.BYTE_VALID_I = 1'b0;
        bus.BYTE_DATA_I  = 8'h00;
        bus.PACK_READY_I = 1'b1;

        wait_cyc(3);
        chk("rst_pack_valid", 96'(bus.PACK_VALID_O), 96'd0);
        chk("rst_pack_data",  bus.PACK_DATA_O,        96'd0);
        chk("rst_byte_ready", 96'(bus.BYTE_READY_O), 96'd1);
        chk("rst_frame_drop", 96'(bus.FRAME_DROP_O), 96'd0);
        rstl = 1'b1;
        wait_cyc(2);

        // Basic frame, MAC always ready: exactly one valid cycle
        v0 = vld_cycles;
        send_seq(vt[0].seq, 0, 11, 0);
        wait_cyc(3);
        chk("t1_valid_cycles", 96'(vld_cycles - v0), 96'd1);
        chk_frame("t1_frame", vt[0].exp);

        // MAC back-pressure with a 13th byte waiting
        bus.PACK_READY_I = 1'b0;
        send_seq(vt[0].seq, 0, 11, 0);
        chk("t2_valid_full", 96'(bus.PACK_VALID_O), 96'd1);
        chk("t2_ready_full", 96'(bus.BYTE_READY_O), 96'd0);
        held = bus.PACK_DATA_O;
        chk("t2_held_data", held, vt[0].exp);
        bus.BYTE_VALID_I = 1'b1;
        bus.BYTE_DATA_I  = 8'hA5;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            if (bus.BYTE_READY_O !== 1'b0 || bus.PACK_VALID_O !== 1'b1 || bus.PACK_DATA_O !== held)
                stable = 1'b0;
        end
        chk("t2_stall_stable", 96'(stable), 96'd1);
        chk("t2_no_early_frame", 96'(rxq.size()), 96'd0);
        bus.PACK_READY_I = 1'b1;
        wait_cyc(1);
        chk("t2_valid_after_hs", 96'(bus.PACK_VALID_O), 96'd0);
        chk("t2_ready_after_hs", 96'(bus.BYTE_READY_O), 96'd1);
        chk_frame("t2_frame", vt[0].exp);
        send_byte(8'hA5);
        send_seq(vt[1].seq, 1, 11, 0);
        wait_cyc(3);
        chk_frame("t2_next_frame", 96'h0C0B0A09_08070605_040302A5);

        // Random upstream gaps across three back-to-back frames
        for (int f = 0; f < 3; f++) send_seq(vt[f].seq, 0, 11, 50);
        wait_cyc(3);
        chk("t3_frame_count", 96'(rxq.size()), 96'd3);
        chk_frame("t3_frame0", vt[0].exp);
        chk_frame("t3_frame1", vt[1].exp);
        chk_frame("t3_frame2", vt[2].exp);

        // Reset mid-frame
        send_seq(vt[2].seq, 0, 4, 0);
        #2;
        rstl = 1'b0;
        #1;
        chk("t4_rst_valid", 96'(bus.PACK_VALID_O), 96'd0);
        chk("t4_rst_ready", 96'(bus.BYTE_READY_O), 96'd1);
        chk("t4_rst_data",  bus.PACK_DATA_O,        96'd0);
        wait_cyc(2);
        rstl = 1'b1;
        wait_cyc(1);
        send_seq(vt[3].seq, 0, 11, 0);
        wait_cyc(3);
        chk("t4_frame_count", 96'(rxq.size()), 96'd1);
        chk_frame("t4_frame", vt[3].exp);

`ifdef FP32_PACK_TIMEOUT_EN
        // Partial frame discarded after the idle timeout
        send_seq(vt[1].seq, 0, 6, 0);
        wait_cyc(110);
        chk("t5_drop_once", 96'(drop_cycles), 96'd1);
        send_seq(vt[0].seq, 0, 11, 0);
        wait_cyc(3);
        chk_frame("t5_after_drop", vt[0].exp);
        // Byte landing in the expiry cycle keeps the partial frame
        send_seq(vt[2].seq, 0, 6, 0);
        wait_cyc(99);
        send_byte(vt[2].seq[95-8*7 -: 8]);
        wait_cyc(50);
        send_seq(vt[2].seq, 8, 11, 0);
        wait_cyc(3);
        chk_frame("t5_expiry_byte", vt[2].exp);
        chk("t5_drop_total", 96'(drop_cycles), 96'd1);
`else
        // Partial frame waits indefinitely
        send_seq(vt[1].seq, 0, 6, 0);
        wait_cyc(5000);
        chk("t6_idle_valid", 96'(bus.PACK_VALID_O), 96'd0);
        chk("t6_idle_ready", 96'(bus.BYTE_READY_O), 96'd1);
        send_seq(vt[1].seq, 7, 11, 0);
        wait_cyc(3);
        chk("t6_frame_count", 96'(rxq.size()), 96'd1);
        chk_frame("t6_frame", vt[1].exp);
        chk("t6_no_drop", 96'(drop_cycles), 96'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
